// File: rtl/alu_seq_divider.sv
// Iterative signed divider for the ALU division opcode.
// Radix-2 restoring division on operand magnitudes, one quotient bit per clock,
// followed by a sign fix-up on the final step. Ready/valid handshake on both sides.
module alu_seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] lhs,
   input  logic [WIDTH-1:0] rhs,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;
   logic   accept;

   logic [CW-1:0]  count;      // remaining restoring steps minus one
   logic [WIDTH-1:0] dvd;      // dividend magnitude shifting out, quotient bits shifting in
   logic [WIDTH:0]   dsr;      // divisor magnitude, zero-extended to the partial remainder width
   logic [WIDTH-1:0] rem_mag;  // partial remainder magnitude (always below the divisor)
   logic             q_neg;    // quotient must be negated at the end
   logic             r_neg;    // remainder must be negated at the end

   logic             rhs_zero;
   logic [WIDTH-1:0] lhs_abs;
   logic [WIDTH-1:0] rhs_abs;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;
   logic             q_bit;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] dvd_step;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_fix;

   // Operand magnitudes and one restoring step with its sign-corrected result.
   // The magnitude of the most negative operand is 2^(WIDTH-1), which still fits
   // WIDTH bits when read as unsigned.
   always_comb begin
      rhs_zero = (rhs == '0);
      lhs_abs  = lhs[WIDTH-1] ? ('0 - lhs) : lhs;
      rhs_abs  = rhs[WIDTH-1] ? ('0 - rhs) : rhs;
      trial    = {rem_mag, dvd[WIDTH-1]};
      diff     = trial - dsr;
      // trial < 2*dsr, so the top bit of diff is set exactly when the subtraction borrowed
      q_bit    = ~diff[WIDTH];
      rem_step = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
      dvd_step = {dvd[WIDTH-2:0], q_bit};
      q_fix    = q_neg ? ('0 - dvd_step) : dvd_step;
      r_fix    = r_neg ? ('0 - rem_step) : rem_step;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs; flush overrides every other transition.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !flush) begin
               accept     = 1'b1;
               state_next = rhs_zero ? DONE : CALC;
            end
         end
         CALC: begin
            if (count == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   // Datapath: latch operands on accept, iterate in CALC, publish results on the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= '0;
         dvd         <= '0;
         dsr         <= '0;
         rem_mag     <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         count       <= CW'(WIDTH - 1);
         dvd         <= lhs_abs;
         dsr         <= {1'b0, rhs_abs};
         rem_mag     <= '0;
         q_neg       <= lhs[WIDTH-1] ^ rhs[WIDTH-1];
         r_neg       <= lhs[WIDTH-1];
         div_by_zero <= rhs_zero;
         if (rhs_zero) begin
            quotient  <= '1;
            remainder <= lhs;
         end
      end else if (state == CALC && !flush) begin
         count   <= count - 1'b1;
         dvd     <= dvd_step;
         rem_mag <= rem_step;
         if (count == '0) begin
            quotient  <= q_fix;
            remainder <= r_fix;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_divider.sv
// Directed self-checking bench for alu_seq_divider (WIDTH = 16).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_seq_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;
   logic         out_ready = 1'b0;
   logic [W-1:0] lhs = '0;
   logic [W-1:0] rhs = '0;
   logic         in_ready;
   logic         out_valid;
   logic         div_by_zero;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;

   int checks = 0;
   int errors = 0;

   alu_seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .lhs         (lhs),
      .rhs         (rhs),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // Present one operation, wait (bounded) for the result, then consume it.
   // lat counts falling edges after the accept edge until out_valid is seen.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dbz, output int lat, output logic rdy);
      @(negedge clk);
      rdy = in_ready;
      lhs = a;
      rhs = b;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lhs = 16'h5A5A;
      rhs = 16'h0000;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      q = quotient;
      r = remainder;
      dbz = div_by_zero;
      $display("op lhs=%0d rhs=%0d -> q=%0d r=%0d dbz=%b lat=%0d",
               $signed(a), $signed(b), $signed(q), $signed(r), dbz, lat);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (out_valid !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got v=%b q=%h r=%h dbz=%b want 0 0 0 0",
                  out_valid, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      end
      $display("reset released in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   task automatic test_basic();
      logic [W-1:0] q, r;
      logic dbz, rdy;
      int lat;
      do_op(16'd7, 16'd2, q, r, dbz, lat, rdy);
      checks++;
      if (rdy !== 1'b1) begin
         errors++;
         $display("FAIL basic_in_ready got %b want 1", rdy);
      end
      checks++;
      if (lat != 17) begin
         errors++;
         $display("FAIL basic_latency got %0d want 17", lat);
      end
      checks++;
      if (q !== 16'd3 || r !== 16'd1 || dbz !== 1'b0) begin
         errors++;
         $display("FAIL basic_result got q=%0d r=%0d dbz=%b want q=3 r=1 dbz=0",
                  $signed(q), $signed(r), dbz);
      end
   endtask

   task automatic test_signs();
      logic [W-1:0] a_tab [7] = '{16'hFFF9, 16'd7,    16'hFFF9, 16'd32767, 16'h8000, 16'h8000, 16'd1000};
      logic [W-1:0] b_tab [7] = '{16'd2,    16'hFFFE, 16'hFFFE, 16'hFFFF,  16'd1,    16'd7,    16'hFFF1};
      logic [W-1:0] q_tab [7] = '{16'hFFFD, 16'hFFFD, 16'd3,    16'h8001,  16'h8000, 16'hEDB7, 16'hFFBE};
      logic [W-1:0] r_tab [7] = '{16'hFFFF, 16'd1,    16'hFFFF, 16'd0,     16'd0,    16'hFFFF, 16'd10};
      logic [W-1:0] q, r;
      logic dbz, rdy;
      int lat;
      for (int i = 0; i < 7; i++) begin
         do_op(a_tab[i], b_tab[i], q, r, dbz, lat, rdy);
         checks++;
         if (q !== q_tab[i] || r !== r_tab[i] || dbz !== 1'b0 || lat != 17) begin
            errors++;
            $display("FAIL sign_%0d got q=%0d r=%0d dbz=%b lat=%0d want q=%0d r=%0d dbz=0 lat=17",
                     i, $signed(q), $signed(r), dbz, lat, $signed(q_tab[i]), $signed(r_tab[i]));
         end
      end
   endtask

   task automatic test_overflow_div0();
      logic [W-1:0] q, r;
      logic dbz, rdy;
      int lat;
      do_op(16'h8000, 16'hFFFF, q, r, dbz, lat, rdy);
      checks++;
      if (q !== 16'h8000 || r !== 16'd0 || dbz !== 1'b0 || lat != 17) begin
         errors++;
         $display("FAIL overflow got q=%h r=%h dbz=%b lat=%0d want q=8000 r=0000 dbz=0 lat=17", q, r, dbz, lat);
      end
      do_op(16'd5, 16'd0, q, r, dbz, lat, rdy);
      checks++;
      if (q !== 16'hFFFF || r !== 16'd5 || dbz !== 1'b1 || lat != 1) begin
         errors++;
         $display("FAIL div0_pos got q=%h r=%h dbz=%b lat=%0d want q=ffff r=0005 dbz=1 lat=1", q, r, dbz, lat);
      end
      do_op(16'hFFF7, 16'd0, q, r, dbz, lat, rdy);
      checks++;
      if (q !== 16'hFFFF || r !== 16'hFFF7 || dbz !== 1'b1 || lat != 1) begin
         errors++;
         $display("FAIL div0_neg got q=%h r=%h dbz=%b lat=%0d want q=ffff r=fff7 dbz=1 lat=1", q, r, dbz, lat);
      end
      do_op(16'd20, 16'd6, q, r, dbz, lat, rdy);
      checks++;
      if (q !== 16'd3 || r !== 16'd2 || dbz !== 1'b0) begin
         errors++;
         $display("FAIL div0_clear got q=%0d r=%0d dbz=%b want q=3 r=2 dbz=0", $signed(q), $signed(r), dbz);
      end
   endtask

   task automatic test_exhaustive();
      logic [W-1:0] q, r;
      logic dbz, rdy;
      int lat;
      int eq, er;
      for (int a = 2; a <= 29; a++) begin
         for (int b = 2; b <= 29; b++) begin
            do_op(W'(a), W'(b), q, r, dbz, lat, rdy);
            eq = a / b;
            er = a % b;
            checks++;
            if (q !== W'(eq) || r !== W'(er) || dbz !== 1'b0) begin
               errors++;
               $display("FAIL exh_%0d_%0d got q=%0d r=%0d dbz=%b want q=%0d r=%0d dbz=0",
                        a, b, $signed(q), $signed(r), dbz, eq, er);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      @(negedge clk);
      lhs = 16'd100;
      rhs = 16'd9;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (lat != 17) begin
         errors++;
         $display("FAIL bp_latency got %0d want 17", lat);
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         lhs = W'(i + 1);
         rhs = 16'd1;
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd11 ||
             remainder !== 16'd1 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d got v=%b rdy=%b q=%0d r=%0d dbz=%b want v=1 rdy=0 q=11 r=1 dbz=0",
                     i, out_valid, in_ready, $signed(quotient), $signed(remainder), div_by_zero);
         end
      end
      $display("backpressure held 10 cycles q=%0d r=%0d", $signed(quotient), $signed(remainder));
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd11) begin
         errors++;
         $display("FAIL bp_release got rdy=%b v=%b q=%0d want rdy=1 v=0 q=11",
                  in_ready, out_valid, $signed(quotient));
      end
   endtask

   task automatic test_flush();
      logic [W-1:0] q, r;
      logic dbz, rdy;
      int lat;
      bit seen;
      // flush beats an accept in IDLE
      @(negedge clk);
      lhs = 16'd40;
      rhs = 16'd5;
      in_valid = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_idle_accept got in_ready=%b want 1", in_ready);
      end
      // flush at CALC cycle 8 with in_valid held high
      @(negedge clk);
      lhs = 16'd50;
      rhs = 16'd3;
      in_valid = 1'b1;
      @(negedge clk);
      lhs = 16'd77;
      repeat (7) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd11 || remainder !== 16'd1) begin
         errors++;
         $display("FAIL flush_calc got rdy=%b v=%b q=%0d r=%0d want rdy=1 v=0 q=11 r=1",
                  in_ready, out_valid, $signed(quotient), $signed(remainder));
      end
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL flush_no_result got out_valid seen=1 want 0");
      end
      $display("flush discarded in-flight op, in_ready=%b", in_ready);
      do_op(16'd100, 16'd7, q, r, dbz, lat, rdy);
      checks++;
      if (q !== 16'd14 || r !== 16'd2 || dbz !== 1'b0 || lat != 17 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL flush_next_op got q=%0d r=%0d dbz=%b lat=%0d rdy=%b want q=14 r=2 dbz=0 lat=17 rdy=1",
                  $signed(q), $signed(r), dbz, lat, rdy);
      end
      // flush while a result is waiting in DONE, together with out_ready
      @(negedge clk);
      lhs = 16'd8;
      rhs = 16'd3;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      flush = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (lat != 17 || out_valid !== 1'b0 || in_ready !== 1'b1 || quotient !== 16'd2 || remainder !== 16'd2) begin
         errors++;
         $display("FAIL flush_done got lat=%0d v=%b rdy=%b q=%0d r=%0d want lat=17 v=0 rdy=1 q=2 r=2",
                  lat, out_valid, in_ready, $signed(quotient), $signed(remainder));
      end
   endtask

   task automatic test_reset_mid_calc();
      logic [W-1:0] q, r;
      logic dbz, rdy;
      int lat;
      bit seen;
      @(negedge clk);
      lhs = 16'd1000;
      rhs = 16'd7;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_calc got v=%b q=%h r=%h dbz=%b want 0 0 0 0",
                  out_valid, quotient, remainder, div_by_zero);
      end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL reset_no_result got out_valid seen=1 want 0");
      end
      do_op(16'd9, 16'd3, q, r, dbz, lat, rdy);
      checks++;
      if (q !== 16'd3 || r !== 16'd0 || dbz !== 1'b0 || lat != 17 || rdy !== 1'b1) begin
         errors++;
         $display("FAIL reset_next_op got q=%0d r=%0d dbz=%b lat=%0d rdy=%b want q=3 r=0 dbz=0 lat=17 rdy=1",
                  $signed(q), $signed(r), dbz, lat, rdy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_overflow_div0();
      test_exhaustive();
      test_backpressure();
      test_flush();
      test_reset_mid_calc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
